// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer between DCT stage 1 (column engine) and stage 2 (row engine).
// Optional macro DCT_TRANSPOSE_SAT_EN: saturate instead of wrap when SIZE_OUT < SIZE.
module dct_transpose_buf #(
  parameter int unsigned SIZE     = 10,
  parameter int unsigned SIZE_OUT = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0][7:0][SIZE-1:0]      data_in,
  input  logic                           stage_done,
  output logic [7:0][SIZE_OUT-1:0]       row_out,
  output logic [2:0]                     row_idx,
  output logic                           row_valid,
  input  logic                           row_ready,
  output logic                           block_last,
  output logic                           busy,
  output logic                           overflow
);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e                    state_q;
  logic                      sd_q;
  logic [1:0]                full_q;
  logic [1:0]                full_d;
  logic                      wr_bank_q;
  logic                      rd_bank_q;
  logic [2:0]                row_idx_q;
  logic                      row_valid_q;
  logic                      block_last_q;
  logic                      overflow_q;
  logic [7:0][7:0][SIZE-1:0] bank_q [2];

  logic cap;
  logic cap_ok;
  logic accept;
  logic last_accept;

  assign cap         = stage_done & ~sd_q;
  assign cap_ok      = cap & ~full_q[wr_bank_q];
  assign accept      = row_valid_q & row_ready;
  assign last_accept = accept & (row_idx_q == 3'd7);

  // Signed resize: sign-extend or wrap, optionally saturate when narrowing.
  function automatic logic [SIZE_OUT-1:0] conv(input logic [SIZE-1:0] x);
    int v;
    v = int'($signed(x));
`ifdef DCT_TRANSPOSE_SAT_EN
    if (SIZE_OUT < SIZE) begin
      if (v > ((1 << (SIZE_OUT - 1)) - 1)) begin
        v = (1 << (SIZE_OUT - 1)) - 1;
      end else if (v < -(1 << (SIZE_OUT - 1))) begin
        v = -(1 << (SIZE_OUT - 1));
      end
    end
`endif
    return SIZE_OUT'(v);
  endfunction

  // Release of the streaming bank and capture into the write bank never hit the same bank.
  always_comb begin
    full_d = full_q;
    if (last_accept) full_d[rd_bank_q] = 1'b0;
    if (cap_ok)      full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && cap_ok) bank_q[wr_bank_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      sd_q         <= 1'b0;
      full_q       <= 2'b00;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      row_idx_q    <= 3'd0;
      row_valid_q  <= 1'b0;
      block_last_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sd_q   <= stage_done;
      full_q <= full_d;
      if (cap) begin
        if (full_q[wr_bank_q]) overflow_q <= 1'b1;
        else                   wr_bank_q  <= ~wr_bank_q;
      end
      case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q      <= STREAM;
            row_valid_q  <= 1'b1;
            row_idx_q    <= 3'd0;
            block_last_q <= 1'b0;
          end
        end
        STREAM: begin
          if (accept) begin
            if (row_idx_q == 3'd7) begin
              rd_bank_q    <= ~rd_bank_q;
              row_idx_q    <= 3'd0;
              block_last_q <= 1'b0;
              // Back-to-back blocks stream without a bubble.
              if (!full_q[~rd_bank_q]) begin
                state_q     <= IDLE;
                row_valid_q <= 1'b0;
              end
            end else begin
              row_idx_q    <= row_idx_q + 3'd1;
              block_last_q <= (row_idx_q == 3'd6);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    row_out = '0;
    if (row_valid_q) begin
      for (int c = 0; c < 8; c++) begin
        row_out[c] = conv(bank_q[rd_bank_q][c][row_idx_q]);
      end
    end
  end

  assign row_idx    = row_idx_q;
  assign row_valid  = row_valid_q;
  assign block_last = block_last_q;
  assign busy       = full_q[0] | full_q[1];
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed bench for dct_transpose_buf: transpose, backpressure, ping-pong, overflow, reset, width.
module tb_dct_transpose_buf;

  localparam int unsigned SIZE = 10;
  localparam int unsigned SW   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [7:0][7:0][SIZE-1:0] data_in;
  logic                      stage_done;
  logic [7:0][SIZE-1:0]      row_out;
  logic [2:0]                row_idx;
  logic                      row_valid;
  logic                      row_ready;
  logic                      block_last;
  logic                      busy;
  logic                      overflow;

  logic [7:0][7:0][SIZE-1:0] data_w;
  logic                      sd_w;
  logic [7:0][SW-1:0]        row_out_w;
  logic [2:0]                idx_w;
  logic                      valid_w;
  logic                      ready_w;
  logic                      last_w;
  logic                      busy_w;
  logic                      ovf_w;

  dct_transpose_buf #(.SIZE(SIZE), .SIZE_OUT(SIZE)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .stage_done(stage_done),
    .row_out(row_out), .row_idx(row_idx), .row_valid(row_valid), .row_ready(row_ready),
    .block_last(block_last), .busy(busy), .overflow(overflow)
  );

  dct_transpose_buf #(.SIZE(SIZE), .SIZE_OUT(SW)) dut_w (
    .clk(clk), .rst(rst), .data_in(data_w), .stage_done(sd_w),
    .row_out(row_out_w), .row_idx(idx_w), .row_valid(valid_w), .row_ready(ready_w),
    .block_last(last_w), .busy(busy_w), .overflow(ovf_w)
  );

  typedef struct {
    logic       sd;
    logic       rdy;
    logic       e_valid;
    logic [2:0] e_idx;
    logic       e_last;
    logic       e_busy;
    logic       e_ovf;
  } vec_t;

  vec_t vt [10];
  int   n_vec = 0;
  int   n_err = 0;

`ifdef DCT_TRANSPOSE_SAT_EN
  localparam logic [SW-1:0] E_POS = 8'd127;
  localparam logic [SW-1:0] E_NEG = 8'h80;
`else
  localparam logic [SW-1:0] E_POS = 8'd44;
  localparam logic [SW-1:0] E_NEG = 8'hD4;
`endif

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0][SIZE-1:0] pat_row(input int k);
    logic [7:0][SIZE-1:0] r;
    for (int c = 0; c < 8; c++) r[c] = SIZE'(8 * c + k);
    return r;
  endfunction

  function automatic logic [7:0][SIZE-1:0] const_row(input int v);
    logic [7:0][SIZE-1:0] r;
    for (int c = 0; c < 8; c++) r[c] = SIZE'(v);
    return r;
  endfunction

  task automatic load_pat();
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++) data_in[c][k] = SIZE'(8 * c + k);
  endtask

  task automatic load_const(input int v);
    for (int c = 0; c < 8; c++)
      for (int k = 0; k < 8; k++) data_in[c][k] = SIZE'(v);
  endtask

  task automatic step(input logic sd, input logic rdy);
    @(negedge clk);
    stage_done = sd;
    row_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; stage_done = 1'b0; row_ready = 1'b0; sd_w = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_state(input string nm, input logic v, input logic [2:0] i,
                           input logic l, input logic b, input logic o);
    chk({nm, " valid"}, 128'(row_valid), 128'(v));
    chk({nm, " idx"},   128'(row_idx),   128'(i));
    chk({nm, " last"},  128'(block_last), 128'(l));
    chk({nm, " busy"},  128'(busy),      128'(b));
    chk({nm, " ovf"},   128'(overflow),  128'(o));
  endtask

  int acc;

  initial begin
    rst = 1'b1; stage_done = 1'b0; row_ready = 1'b0; sd_w = 1'b0; ready_w = 1'b0;
    data_in = '0; data_w = '0;

    vt[0] = '{sd:1'b1, rdy:1'b1, e_valid:1'b0, e_idx:3'd0, e_last:1'b0, e_busy:1'b1, e_ovf:1'b0};
    vt[1] = '{sd:1'b1, rdy:1'b1, e_valid:1'b1, e_idx:3'd0, e_last:1'b0, e_busy:1'b1, e_ovf:1'b0};
    for (int i = 2; i < 9; i++)
      vt[i] = '{sd:1'b0, rdy:1'b1, e_valid:1'b1, e_idx:3'(i - 1), e_last:(i == 8),
                e_busy:1'b1, e_ovf:1'b0};
    vt[9] = '{sd:1'b0, rdy:1'b1, e_valid:1'b0, e_idx:3'd0, e_last:1'b0, e_busy:1'b0, e_ovf:1'b0};

    // Reset state
    do_reset();
    chk_state("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("reset row", 128'(row_out), 128'(0));

    // Basic transpose from the vector table
    load_pat();
    for (int i = 0; i < 10; i++) begin
      step(vt[i].sd, vt[i].rdy);
      chk_state($sformatf("tr%0d", i), vt[i].e_valid, vt[i].e_idx, vt[i].e_last,
                vt[i].e_busy, vt[i].e_ovf);
      chk($sformatf("tr%0d row", i), 128'(row_out),
          vt[i].e_valid ? 128'(pat_row(int'(vt[i].e_idx))) : 128'(0));
    end

    // Backpressure at row 2
    do_reset();
    load_pat();
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    chk_state("bp pre", 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk($sformatf("bp hold%0d idx", i), 128'(row_idx), 128'(2));
      chk($sformatf("bp hold%0d row", i), 128'(row_out), 128'(pat_row(2)));
    end
    for (int k = 3; k < 8; k++) begin
      step(1'b0, 1'b1);
      chk($sformatf("bp r%0d idx", k), 128'(row_idx), 128'(k));
      chk($sformatf("bp r%0d row", k), 128'(row_out), 128'(pat_row(k)));
    end
    step(1'b0, 1'b1);
    chk_state("bp end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Ping-pong: B captured while A shows row 4
    do_reset();
    load_const(5);
    step(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("pp a4 idx", 128'(row_idx), 128'(4));
    load_const(-7);
    step(1'b1, 1'b1);
    chk("pp a5 row", 128'(row_out), 128'(const_row(5)));
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_state("pp a7", 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    chk("pp a7 row", 128'(row_out), 128'(const_row(5)));
    step(1'b0, 1'b1);
    chk_state("pp b0", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("pp b0 row", 128'(row_out), 128'(const_row(-7)));
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    chk_state("pp b7", 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk_state("pp end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Overflow: third block dropped
    do_reset();
    load_const(1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    load_const(2);
    step(1'b1, 1'b0);
    chk("ov after2", 128'(overflow), 128'(0));
    step(1'b0, 1'b0);
    load_const(3);
    step(1'b1, 1'b0);
    chk("ov after3", 128'(overflow), 128'(1));
    chk("ov row0", 128'(row_out), 128'(const_row(1)));
    for (int j = 1; j < 16; j++) begin
      step(1'b0, 1'b1);
      chk($sformatf("ov j%0d idx", j), 128'(row_idx), 128'(j % 8));
      chk($sformatf("ov j%0d row", j), 128'(row_out), 128'(const_row(j < 8 ? 1 : 2)));
    end
    step(1'b0, 1'b1);
    chk_state("ov end", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream clears everything including overflow
    load_pat();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("rs pre valid", 128'(row_valid), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_state("rs", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk_state("rs after", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Level held high yields one block
    do_reset();
    load_pat();
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (row_valid) acc++;
      step(i < 20, 1'b1);
    end
    chk("lvl accepts", 128'(acc), 128'(8));
    chk("lvl busy", 128'(busy), 128'(0));

    // Narrowing to 8 bits
    do_reset();
    for (int k = 0; k < 8; k++) begin
      data_w[0][k] = SIZE'(300);
      data_w[1][k] = SIZE'(-300);
    end
    @(negedge clk);
    sd_w = 1'b1; ready_w = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sd_w = 1'b0;
    @(posedge clk);
    #1;
    chk("w valid", 128'(valid_w), 128'(1));
    chk("w idx", 128'(idx_w), 128'(0));
    chk("w last", 128'(last_w), 128'(0));
    chk("w busy", 128'(busy_w), 128'(1));
    chk("w ovf", 128'(ovf_w), 128'(0));
    chk("w pos", 128'(row_out_w[0]), 128'(E_POS));
    chk("w neg", 128'(row_out_w[1]), 128'(E_NEG));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
